// File: rtl/player_pkg.sv
// ============================================================================
//  Module   : player_pkg
//  Brief    : Shared transport-state encodings and elapsed-seconds width.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package player_pkg;

    // The display logic decodes these codes directly.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int ELAPSED_W = 8;

endpackage

`default_nettype wire

// File: rtl/elapsed_timer.sv
// ============================================================================
//  Module   : elapsed_timer
//  Brief    : Per-second prescaler plus saturating elapsed-seconds counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module elapsed_timer
    import player_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clear,
    output logic [ELAPSED_W-1:0] elapsed_sec
);

    localparam int PRE_W = $clog2(TICKS_PER_SEC);
    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(TICKS_PER_SEC - 1);

    logic [PRE_W-1:0]     r_pre;
    logic [ELAPSED_W-1:0] r_sec;

    // clear outranks run so a reload during PLAY starts from zero
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (run) begin
            if (r_pre == c_pre_last) begin
                r_pre <= '0;
                if (r_sec != '1) begin
                    r_sec <= r_sec + 1'b1;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign elapsed_sec = r_sec;

endmodule

`default_nettype wire

// File: rtl/song_player_ctrl.sv
// ============================================================================
//  Module   : song_player_ctrl
//  Brief    : Transport FSM, song select and elapsed timer for the player.
//             SONG_PLAYER_AUTOPLAY_EN: song_done in PLAY advances to next song.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module song_player_ctrl
    import player_pkg::*;
#(
    parameter int NUM_SONGS     = 4,
    parameter int RESET_CYCLES  = 4,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int SONG_W        = $clog2(NUM_SONGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_play,
    input  logic              btn_stop,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              song_done,
    output logic [SONG_W-1:0] song_sel,
    output logic              play,
    output logic              reset_player,
    output logic [2:0]        state_o,
    output logic [7:0]        elapsed_sec
);

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  c_load_last = CNT_W'(RESET_CYCLES - 1);
    localparam logic [SONG_W-1:0] c_song_last = SONG_W'(NUM_SONGS - 1);

    state_t             r_state;
    logic [SONG_W-1:0]  r_song_sel;
    logic               r_play;
    logic               r_reset_player;
    logic [CNT_W-1:0]   r_load_cnt;

    state_t             w_state_nxt;
    logic [SONG_W-1:0]  w_sel_nxt;
    logic [SONG_W-1:0]  w_sel_inc;
    logic [SONG_W-1:0]  w_sel_step;
    logic               w_evt_stop;
    logic               w_evt_done;
    logic               w_evt_step;
    logic               w_evt_play;
    logic               w_clear;

    // Only the highest-priority event of a cycle is allowed to act.
    always_comb begin
        w_evt_stop = btn_stop;
        w_evt_done = !btn_stop && song_done;
        w_evt_step = !btn_stop && !song_done && (btn_next || btn_prev);
        w_evt_play = !btn_stop && !song_done && !btn_next && !btn_prev && btn_play;

        w_sel_inc  = (r_song_sel == c_song_last) ? '0 : r_song_sel + 1'b1;
        if (btn_next) begin
            w_sel_step = w_sel_inc;
        end else begin
            w_sel_step = (r_song_sel == '0) ? c_song_last : r_song_sel - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_song_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_evt_step) begin
                    w_sel_nxt = w_sel_step;
                end else if (w_evt_play) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_evt_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_load_cnt == c_load_last) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_evt_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_evt_done) begin
`ifdef SONG_PLAYER_AUTOPLAY_EN
                    w_sel_nxt   = w_sel_inc;
                    w_state_nxt = ST_LOAD;
`else
                    w_state_nxt = ST_DONE;
`endif
                end else if (w_evt_step) begin
                    w_sel_nxt   = w_sel_step;
                    w_state_nxt = ST_LOAD;
                end else if (w_evt_play) begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_evt_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_evt_step) begin
                    w_sel_nxt   = w_sel_step;
                    w_state_nxt = ST_LOAD;
                end else if (w_evt_play) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_DONE: begin
                if (w_evt_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_evt_step) begin
                    w_sel_nxt   = w_sel_step;
                    w_state_nxt = ST_IDLE;
                end else if (w_evt_play) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_song_sel     <= '0;
            r_play         <= 1'b0;
            r_reset_player <= 1'b1;
            r_load_cnt     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_song_sel     <= w_sel_nxt;
            r_play         <= (w_state_nxt == ST_PLAY);
            r_reset_player <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD) ||
                              (w_state_nxt == ST_DONE);
            // counter restarts on every entry into LOAD
            if ((r_state == ST_LOAD) && (w_state_nxt == ST_LOAD)) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end else begin
                r_load_cnt <= '0;
            end
        end
    end

    // Clearing on the transition edge keeps elapsed_sec aligned with state_o.
    assign w_clear = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);

    elapsed_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_elapsed_timer (
        .clk         (clk),
        .rst         (rst),
        .run         (r_state == ST_PLAY),
        .clear       (w_clear),
        .elapsed_sec (elapsed_sec)
    );

    assign song_sel     = r_song_sel;
    assign play         = r_play;
    assign reset_player = r_reset_player;
    assign state_o      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_song_player_ctrl.sv
// ============================================================================
//  Module   : tb_song_player_ctrl
//  Brief    : Scenario bench for song_player_ctrl with a scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_song_player_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_play = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       song_done = 1'b0;
    logic [1:0] song_sel;
    logic       play;
    logic       reset_player;
    logic [2:0] state_o;
    logic [7:0] elapsed_sec;

    // {song_sel, play, reset_player, state_o, elapsed_sec}
    logic [14:0] obs;
    assign obs = {song_sel, play, reset_player, state_o, elapsed_sec};

    typedef struct {
        string       name;
        logic [14:0] v;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    song_player_ctrl #(
        .NUM_SONGS     (4),
        .RESET_CYCLES  (4),
        .TICKS_PER_SEC (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_play     (btn_play),
        .btn_stop     (btn_stop),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .song_done    (song_done),
        .song_sel     (song_sel),
        .play         (play),
        .reset_player (reset_player),
        .state_o      (state_o),
        .elapsed_sec  (elapsed_sec)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ev(input logic [1:0] sel, input logic pl, input logic rp,
                                       input logic [2:0] st, input logic [7:0] sec);
        return {sel, pl, rp, st, sec};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string name, input logic [14:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        push("reset", ev(2'd0, 1'b0, 1'b1, 3'd0, 8'd0));
        tick(2);
        rst = 1'b0;
        e = q.pop_front();
        n_checks++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        else n_pass++;
    endtask

    task automatic test_play_load();
        exp_t e;
        btn_play = 1'b1;
        for (int i = 1; i <= 4; i++) push($sformatf("load_c%0d", i), ev(2'd0, 1'b0, 1'b1, 3'd1, 8'd0));
        push("load_to_play", ev(2'd0, 1'b1, 1'b0, 3'd2, 8'd0));
        for (int i = 0; i < 5; i++) begin
            tick();
            btn_play = 1'b0;
            e = q.pop_front();
            n_checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            else n_pass++;
        end
    endtask

    task automatic test_elapsed();
        exp_t e;
        // tick counts are PLAY cycles completed since entering PLAY
        push("sec_at_9",  ev(2'd0, 1'b1, 1'b0, 3'd2, 8'd0));
        push("sec_at_10", ev(2'd0, 1'b1, 1'b0, 3'd2, 8'd1));
        push("sec_at_35", ev(2'd0, 1'b1, 1'b0, 3'd2, 8'd3));
        for (int i = 0; i < 3; i++) begin
            tick((i == 0) ? 9 : (i == 1) ? 1 : 25);
            e = q.pop_front();
            n_checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            else n_pass++;
        end
        btn_play = 1'b1;
        push("pause_enter", ev(2'd0, 1'b0, 1'b0, 3'd3, 8'd3));
        push("pause_hold",  ev(2'd0, 1'b0, 1'b0, 3'd3, 8'd3));
        push("resume",      ev(2'd0, 1'b1, 1'b0, 3'd2, 8'd3));
        push("resume_3",    ev(2'd0, 1'b1, 1'b0, 3'd2, 8'd3));
        push("resume_5",    ev(2'd0, 1'b1, 1'b0, 3'd2, 8'd4));
        for (int i = 0; i < 5; i++) begin
            case (i)
                1: tick(19);
                2: begin btn_play = 1'b1; tick(); end
                3: tick(3);
                4: tick(2);
                default: tick();
            endcase
            btn_play = 1'b0;
            e = q.pop_front();
            n_checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            else n_pass++;
        end
    endtask

    task automatic test_next_reload();
        exp_t e;
        btn_next = 1'b1;
        for (int i = 1; i <= 4; i++) push($sformatf("next_reload_c%0d", i), ev(2'd1, 1'b0, 1'b1, 3'd1, 8'd0));
        push("next_replay", ev(2'd1, 1'b1, 1'b0, 3'd2, 8'd0));
        for (int i = 0; i < 5; i++) begin
            tick();
            btn_next = 1'b0;
            e = q.pop_front();
            n_checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        // stop, next, next, next (3->0), prev (0->3), prev
        push("stop_idle",  ev(2'd1, 1'b0, 1'b1, 3'd0, 8'd0));
        push("next_2",     ev(2'd2, 1'b0, 1'b1, 3'd0, 8'd0));
        push("next_3",     ev(2'd3, 1'b0, 1'b1, 3'd0, 8'd0));
        push("next_wrap",  ev(2'd0, 1'b0, 1'b1, 3'd0, 8'd0));
        push("prev_wrap",  ev(2'd3, 1'b0, 1'b1, 3'd0, 8'd0));
        push("prev_2",     ev(2'd2, 1'b0, 1'b1, 3'd0, 8'd0));
        for (int i = 0; i < 6; i++) begin
            btn_stop = (i == 0);
            btn_next = (i >= 1 && i <= 3);
            btn_prev = (i >= 4);
            tick();
            btn_stop = 1'b0;
            btn_next = 1'b0;
            btn_prev = 1'b0;
            e = q.pop_front();
            n_checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        exp_t e;
        btn_play = 1'b1;
        tick();
        btn_play = 1'b0;
        push("prio_play", ev(2'd2, 1'b1, 1'b0, 3'd2, 8'd0));
        push("prio_sec",  ev(2'd2, 1'b1, 1'b0, 3'd2, 8'd1));
        push("prio_stop", ev(2'd2, 1'b0, 1'b1, 3'd0, 8'd0));
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                btn_stop  = 1'b1;
                song_done = 1'b1;
                btn_next  = 1'b1;
            end
            tick((i == 0) ? 4 : (i == 1) ? 12 : 1);
            btn_stop  = 1'b0;
            song_done = 1'b0;
            btn_next  = 1'b0;
            e = q.pop_front();
            n_checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            else n_pass++;
        end
    endtask

    task automatic test_song_done();
        exp_t e;
        btn_play = 1'b1;
        tick();
        btn_play = 1'b0;
        tick(7);
        song_done = 1'b1;
`ifdef SONG_PLAYER_AUTOPLAY_EN
        push("done_autoplay", ev(2'd3, 1'b0, 1'b1, 3'd1, 8'd0));
`else
        push("done_state", ev(2'd2, 1'b0, 1'b1, 3'd4, 8'd0));
`endif
        tick();
        song_done = 1'b0;
        e = q.pop_front();
        n_checks++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        else n_pass++;
`ifndef SONG_PLAYER_AUTOPLAY_EN
        btn_prev = 1'b1;
        push("done_prev_idle", ev(2'd1, 1'b0, 1'b1, 3'd0, 8'd0));
        tick();
        btn_prev = 1'b0;
        e = q.pop_front();
        n_checks++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        else n_pass++;
`endif
    endtask

    task automatic test_rst_mid();
        exp_t e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        btn_play = 1'b1;
        tick();
        btn_play = 1'b0;
        tick(2);
        rst = 1'b1;
        btn_next = 1'b1;
        push("rst_mid_load", ev(2'd0, 1'b0, 1'b1, 3'd0, 8'd0));
        tick();
        rst = 1'b0;
        btn_next = 1'b0;
        e = q.pop_front();
        n_checks++;
        if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        else n_pass++;
        btn_play = 1'b1;
        tick();
        btn_play = 1'b0;
        tick(4);
        push("play_sec7",     ev(2'd0, 1'b1, 1'b0, 3'd2, 8'd7));
        push("rst_mid_play",  ev(2'd0, 1'b0, 1'b1, 3'd0, 8'd0));
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                rst = 1'b1;
                btn_play = 1'b1;
            end
            tick((i == 0) ? 70 : 1);
            rst = 1'b0;
            btn_play = 1'b0;
            e = q.pop_front();
            n_checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_play_load();
        test_elapsed();
        test_next_reload();
        test_wrap();
        test_priority();
        test_song_done();
        test_rst_mid();
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
